bit_scan_serializer: RTL and testbench
======================================

// Module: bit_scan_serializer
// PURPOSE
//  Parametrised successor to the 16:1 bit selector. Holds a WIDTH-bit word and emits it one bit
//  per step tick: either a sequential scan (UART TX data path) or single registered random-access
//  reads. Sits between the counter/data source and the UART bit-timing logic (step = baud tick).
// PARAMETERS
//  WIDTH      16  word width in bits, 2..256
//  ADDR_W     4   index width; must equal clog2(WIDTH)
//  MSB_FIRST  0   0: scan index ascends from 0; 1: scan descends from len-1
// PORTS
//  clk         in   1        system clock, rising edge
//  rst         in   1        asynchronous reset, active-high
//  load_valid  in   1        load request
//  load_ready  out  1        block can accept a load; high only in IDLE
//  load_data   in   WIDTH    word to capture
//  load_len    in   ADDR_W+1 bits to scan, 1..WIDTH; 0 or >WIDTH means WIDTH
//  step        in   1        scan advance strobe; one bit per asserted cycle
//  rd_en       in   1        direct-read request, honoured in IDLE only
//  rd_addr     in   ADDR_W   direct-read index
//  bit_out     out  1        registered selected bit
//  bit_valid   out  1        one-cycle pulse: bit_out/bit_addr updated this cycle
//  bit_addr    out  ADDR_W   index of the bit now on bit_out
//  addr_err    out  1        one-cycle pulse: direct read with rd_addr >= WIDTH
//  busy        out  1        high in RUN
//  done        out  1        one-cycle pulse together with the last scanned bit's bit_valid
// BEHAVIOUR
//  Reset: state IDLE; data_q, idx, remaining count, and all outputs 0 except load_ready (1).
//  FSM IDLE -> RUN on accepted load (load_valid & load_ready); RUN -> IDLE on clock edge that
//   emits last bit. No other transitions except reset.
//  Load: data_q <= load_data; rem <= eff_len; idx <= MSB_FIRST ? eff_len-1 : 0. busy is high
//   and load_ready low from the next cycle.
//  Scan (RUN, step=1 at edge n): at n+1 bit_out=data_q[idx], bit_addr=idx, bit_valid=1;
//   idx +/-1 (per MSB_FIRST); rem-1. If rem was 1: done=1 with bit_valid, state->IDLE,
//   load_ready=1 in the same cycle as done. step=0: outputs hold, bit_valid=0.
//   Back-to-back step every cycle gives one bit per cycle, no bubbles.
//  Direct read (IDLE, rd_en=1, no load accepted): next cycle bit_out=data_q[rd_addr],
//   bit_addr=rd_addr, bit_valid=1, done=0. If rd_addr>=WIDTH (WIDTH not a power of two):
//   bit_out=0, bit_addr=rd_addr, bit_valid=0, addr_err=1.
//  Priority in IDLE: load beats rd_en (read dropped, no pulse); step ignored in IDLE.
//  In RUN: rd_en and load_valid ignored; load_data not sampled.
//  bit_out/bit_addr hold last value between pulses; never X, including after reset.
//  idx never leaves 0..WIDTH-1; the rem counter, not idx wrap, ends the scan.
//  Reset mid-scan: immediate return to IDLE, all outputs 0, no done pulse.
//  Combinational outputs: load_ready, busy (state decodes). Everything else is registered.
// TESTING
//  1 Reset: rst=1 mid-RUN -> bit_valid=0, done=0, busy=0, load_ready=1, bit_out=0 immediately.
//  2 LSB scan: WIDTH=16, load 16'hA5C3, len=0, step every cycle -> bits 1,1,0,0,0,0,1,1,1,0,1,0,
//    0,1,0,1 at addr 0..15; done with 16th bit_valid; load_ready=1 same cycle.
//  3 MSB_FIRST=1, load 16'h00F1, len=5, step every 3rd cycle -> bits at addr 4,3,2,1,0 =
//    1,0,0,0,1; exactly 5 bit_valid pulses, each 1 cycle after its step.
//  4 Direct read: after load 16'h8001 and scan complete, rd_en with rd_addr=15 then 7 ->
//    bit_out=1 then 0 one cycle after each rd_en, with bit_valid pulses; rd_en+load_valid same
//    cycle -> load taken, no read pulse.
//  5 WIDTH=12, ADDR_W=4: rd_addr=13 -> addr_err=1, bit_valid=0; rd_addr=11 -> data_q[11].
//  6 Ignore rules: in RUN toggle load_valid/rd_en with new data -> scan output unchanged; step in
//    IDLE -> no bit_valid.

Source files
------------

// File: rtl/bit_scan_serializer.sv
// Word-wide bit serializer: captures a WIDTH-bit word and emits it one bit per step
// (ascending or descending scan), or serves single registered random-access bit reads.
module bit_scan_serializer #(
  parameter int WIDTH     = 16,
  parameter int ADDR_W    = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [WIDTH-1:0]  load_data,
  input  logic [ADDR_W:0]   load_len,
  input  logic              step,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              bit_out,
  output logic              bit_valid,
  output logic [ADDR_W-1:0] bit_addr,
  output logic              addr_err,
  output logic              busy,
  output logic              done
);

  // state  | meaning
  // S_IDLE | word held; accepts loads and direct reads
  // S_RUN  | scanning; one bit per step until the remaining count hits zero
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam int                DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   LEN_MAX = WIDTH[ADDR_W:0];
  localparam logic [ADDR_W:0]   ONE_L   = 1;
  localparam logic [ADDR_W-1:0] ONE_I   = 1;

  logic [0:0]        state_q;
  logic [WIDTH-1:0]  data_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W:0]   rem_q;

  logic [ADDR_W:0]   eff_len;
  logic [ADDR_W:0]   len_m1;
  logic [ADDR_W-1:0] start_idx;
  logic [ADDR_W-1:0] idx_next;
  logic [DEPTH-1:0]  data_pad;
  logic              rd_ok;

  assign load_ready = (state_q == S_IDLE);
  assign busy       = (state_q == S_RUN);

  always_comb begin
    eff_len = load_len;
    if (load_len == '0 || load_len > LEN_MAX) eff_len = LEN_MAX;
    len_m1    = eff_len - ONE_L;
    start_idx = MSB_FIRST ? len_m1[ADDR_W-1:0] : '0;
    idx_next  = MSB_FIRST ? (idx_q - ONE_I) : (idx_q + ONE_I);
    rd_ok     = ({1'b0, rd_addr} < LEN_MAX);
  end

  // Zero-padded copy so any ADDR_W-bit index is in range when WIDTH is not a power of two.
  always_comb begin
    data_pad = '0;
    data_pad[WIDTH-1:0] = data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      data_q    <= '0;
      idx_q     <= '0;
      rem_q     <= '0;
      bit_out   <= 1'b0;
      bit_addr  <= '0;
      bit_valid <= 1'b0;
      done      <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      bit_valid <= 1'b0;
      done      <= 1'b0;
      addr_err  <= 1'b0;
      if (state_q == S_IDLE) begin
        if (load_valid) begin
          data_q  <= load_data;
          rem_q   <= eff_len;
          idx_q   <= start_idx;
          state_q <= S_RUN;
        end else if (rd_en) begin
          bit_addr <= rd_addr;
          if (rd_ok) begin
            bit_out   <= data_pad[rd_addr];
            bit_valid <= 1'b1;
          end else begin
            bit_out  <= 1'b0;
            addr_err <= 1'b1;
          end
        end
      end else if (step) begin
        bit_out   <= data_pad[idx_q];
        bit_addr  <= idx_q;
        bit_valid <= 1'b1;
        rem_q     <= rem_q - ONE_L;
        // idx holds on the final bit so it never steps outside 0..WIDTH-1.
        if (rem_q == ONE_L) begin
          done    <= 1'b1;
          state_q <= S_IDLE;
        end else begin
          idx_q <= idx_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_bit_scan_serializer.sv
// Scoreboard bench for bit_scan_serializer: three instances (16 LSB-first, 16 MSB-first, 12-bit).
module tb_bit_scan_serializer;

  typedef struct {
    int         id;
    logic       b;
    logic [3:0] a;
    logic       d;
    logic       e;
    int         c;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  logic        lv [3];
  logic [15:0] ld [3];
  logic [4:0]  ll [3];
  logic        st [3];
  logic        re [3];
  logic [3:0]  ra [3];
  logic        lr [3];
  logic        bo [3];
  logic        bv [3];
  logic [3:0]  ba [3];
  logic        ae [3];
  logic        by [3];
  logic        dn [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bit_scan_serializer #(.WIDTH(16), .ADDR_W(4), .MSB_FIRST(1'b0)) u0 (
    .clk(clk), .rst(rst), .load_valid(lv[0]), .load_ready(lr[0]), .load_data(ld[0]),
    .load_len(ll[0]), .step(st[0]), .rd_en(re[0]), .rd_addr(ra[0]), .bit_out(bo[0]),
    .bit_valid(bv[0]), .bit_addr(ba[0]), .addr_err(ae[0]), .busy(by[0]), .done(dn[0]));

  bit_scan_serializer #(.WIDTH(16), .ADDR_W(4), .MSB_FIRST(1'b1)) u1 (
    .clk(clk), .rst(rst), .load_valid(lv[1]), .load_ready(lr[1]), .load_data(ld[1]),
    .load_len(ll[1]), .step(st[1]), .rd_en(re[1]), .rd_addr(ra[1]), .bit_out(bo[1]),
    .bit_valid(bv[1]), .bit_addr(ba[1]), .addr_err(ae[1]), .busy(by[1]), .done(dn[1]));

  bit_scan_serializer #(.WIDTH(12), .ADDR_W(4), .MSB_FIRST(1'b0)) u2 (
    .clk(clk), .rst(rst), .load_valid(lv[2]), .load_ready(lr[2]), .load_data(ld[2][11:0]),
    .load_len(ll[2]), .step(st[2]), .rd_en(re[2]), .rd_addr(ra[2]), .bit_out(bo[2]),
    .bit_valid(bv[2]), .bit_addr(ba[2]), .addr_err(ae[2]), .busy(by[2]), .done(dn[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Monitor: every bit_valid/addr_err pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        if (bv[i] || ae[i]) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_pulse: dut %0d got addr %0d bit %0b, required no pulse", i, ba[i], bo[i]);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk($sformatf("pulse_id@%0d", e.a), i, e.id);
            chk($sformatf("pulse_cycle%0d@%0d", i, e.a), cyc, e.c);
            chk($sformatf("pulse%0d@%0d{b,a,d,e,v}", i, e.a),
                {bo[i], ba[i], dn[i], ae[i], bv[i]}, {e.b, e.a, e.d, e.e, ~e.e});
            if (e.d) chk($sformatf("done_ready%0d", i), {lr[i], by[i]}, 2'b10);
          end
        end
      end
    end
  end

  task automatic push(input int id, input logic b, input logic [3:0] a, input logic d, input logic e);
    exp_t x;
    x = '{id, b, a, d, e, cyc + 1};
    sb.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int i, input logic [15:0] data, input logic [4:0] len);
    chk($sformatf("ready_before_load%0d", i), lr[i], 1'b1);
    lv[i] = 1'b1; ld[i] = data; ll[i] = len;
    tick();
    lv[i] = 1'b0;
    chk($sformatf("busy_after_load%0d", i), {by[i], lr[i]}, 2'b10);
  endtask

  task automatic do_step(input int i, input logic b, input logic [3:0] a, input logic d);
    st[i] = 1'b1;
    push(i, b, a, d, 1'b0);
    tick();
    st[i] = 1'b0;
  endtask

  task automatic do_read(input int i, input logic [3:0] a, input logic b, input logic err);
    re[i] = 1'b1; ra[i] = a;
    push(i, b, a, 1'b0, err);
    tick();
    re[i] = 1'b0;
  endtask

  logic [15:0] v_lsb  = 16'b1010_0101_1100_0011;  // A5C3 bits 15..0
  logic [4:0]  v_msb  = 5'b1_0001;                 // 00F1 bits 4..0
  logic [11:0] v_w12  = 12'b1010_0101_0011;        // A53 bits 11..0
  logic [7:0]  v_run6 = 8'b0000_1111;              // 0F0F bits 7..0

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      lv[i] = 0; ld[i] = '0; ll[i] = '0; st[i] = 0; re[i] = 0; ra[i] = '0;
    end
    tick(); tick();
    for (int i = 0; i < 3; i++)
      chk($sformatf("reset%0d", i), {lr[i], by[i], bv[i], bo[i], ba[i], dn[i], ae[i]}, 10'b1000000000);
    rst = 1'b0;
    tick();

    // Asynchronous reset in the middle of a scan
    do_load(0, 16'hFFFF, 5'd0);
    do_step(0, 1'b1, 4'd0, 1'b0);
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    chk("pre_rst{v,b,busy}", {bv[0], bo[0], by[0]}, 3'b111);
    rst = 1'b1;
    #1;
    chk("rst_async{v,d,busy,ready,b}", {bv[0], dn[0], by[0], lr[0], bo[0]}, 5'b00010);
    chk("rst_async_addr", ba[0], 4'd0);
    tick();
    rst = 1'b0;
    tick();

    // LSB-first full-width scan, step every cycle, len=0 -> 16
    do_load(0, 16'hA5C3, 5'd0);
    for (int k = 0; k < 16; k++) do_step(0, v_lsb[k], 4'(k), k == 15);
    chk("lsb_idle_after_done", {lr[0], by[0]}, 2'b10);

    // MSB-first, len=5, step every third cycle
    do_load(1, 16'h00F1, 5'd5);
    for (int k = 4; k >= 0; k--) begin
      do_step(1, v_msb[k], 4'(k), k == 0);
      tick(); tick();
    end

    // Direct reads after a scan; load beats rd_en in the same cycle
    do_load(0, 16'h8001, 5'd16);
    for (int k = 0; k < 16; k++) do_step(0, (k == 0) || (k == 15), 4'(k), k == 15);
    do_read(0, 4'd15, 1'b1, 1'b0);
    do_read(0, 4'd7, 1'b0, 1'b0);
    re[0] = 1'b1; ra[0] = 4'd3; lv[0] = 1'b1; ld[0] = 16'h0001; ll[0] = 5'd1;
    tick();
    re[0] = 1'b0; lv[0] = 1'b0;
    chk("load_beats_read_busy", by[0], 1'b1);
    do_step(0, 1'b1, 4'd0, 1'b1);
    tick();

    // WIDTH=12: over-long len clamps to 12, out-of-range read flags addr_err
    do_load(2, 16'h0A53, 5'd13);
    for (int k = 0; k < 12; k++) do_step(2, v_w12[k], 4'(k), k == 11);
    do_read(2, 4'd13, 1'b0, 1'b1);
    do_read(2, 4'd11, 1'b1, 1'b0);
    do_read(2, 4'd15, 1'b0, 1'b1);

    // Loads and reads ignored in RUN; step ignored in IDLE
    do_load(0, 16'h0F0F, 5'd8);
    lv[0] = 1'b1; ld[0] = 16'hFFFF; ll[0] = 5'd1; re[0] = 1'b1; ra[0] = 4'd3;
    for (int k = 0; k < 8; k++) begin
      do_step(0, v_run6[k], 4'(k), k == 7);
      if (k != 7) tick();
    end
    lv[0] = 1'b0; re[0] = 1'b0;
    st[0] = 1'b1;
    tick(); tick(); tick();
    st[0] = 1'b0;
    chk("step_in_idle_not_busy", by[0], 1'b0);
    do_read(0, 4'd4, 1'b0, 1'b0);
    do_read(0, 4'd8, 1'b1, 1'b0);

    for (int n = 0; n < 20 && sb.size() != 0; n++) tick();
    tick();
    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
